// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, registered flush/redirect, EX multi-cycle tracking, stall-cycle counter.
// Latency: stall/ex_mc_done are combinational from state+requests; flush/new_pc appear one cycle after flush_req.
// Backpressure: stall[i]=1 holds stage register i; priority flush > mem wait > multi-cycle > load-use.
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_len,
    input  logic                stallreq_mem,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                ex_mc_done,
    output logic                mc_busy,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MC    = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_MC  = 6'b001111;
    localparam logic [5:0] STALL_ID  = 6'b000111;

    logic [1:0]          state, state_nxt;
    logic [MC_CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]          stall_c;
    logic                done_c;
    logic                capture;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = '0;
        done_c    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_RUN: begin
                if (flush_req) begin
                    capture   = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (stallreq_mem) begin
                    stall_c = STALL_MEM;
                end else if (ex_mc_start) begin
                    if (ex_mc_len <= MC_CNT_W'(1)) begin
                        done_c = 1'b1;
                    end else begin
                        stall_c   = STALL_MC;
                        cnt_nxt   = ex_mc_len - MC_CNT_W'(2);
                        state_nxt = S_MC;
                    end
                end else if (stallreq_id) begin
                    stall_c = STALL_ID;
                end
            end
            S_MC: begin
                // load-use is subsumed by the multi-cycle hold, so stallreq_id is not consulted
                if (flush_req) begin
                    capture   = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (stallreq_mem) begin
                    stall_c = STALL_MEM;
                end else if (cnt != '0) begin
                    stall_c = STALL_MC;
                    cnt_nxt = cnt - MC_CNT_W'(1);
                end else begin
                    done_c    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Combinational outputs are gated so they read idle for the whole reset assertion
    assign stall      = rst ? stall_c : '0;
    assign ex_mc_done = rst ? done_c : 1'b0;
    assign mc_busy    = (state == S_MC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            cnt          <= '0;
            flush        <= 1'b0;
            new_pc       <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flush <= capture;
            if (capture) begin
                new_pc <= flush_pc;
            end
            if ((stall_c != '0) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, ex_mc_start, stallreq_mem, flush_req;
    logic [5:0]  ex_mc_len;
    logic [31:0] flush_pc;
    logic [5:0]  stall, stall2;
    logic        flush, flush2, ex_mc_done, ex_mc_done2, mc_busy, mc_busy2;
    logic [31:0] new_pc, new_pc2;
    logic [31:0] stall_cycles;
    logic [1:0]  stall_cycles2;

    int tests = 0;
    int failed = 0;

    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .ex_mc_len(ex_mc_len), .stallreq_mem(stallreq_mem), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
        .ex_mc_done(ex_mc_done), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    // Narrow counter instance exercises saturation quickly
    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .ex_mc_len(ex_mc_len), .stallreq_mem(stallreq_mem), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(stall2), .flush(flush2), .new_pc(new_pc2),
        .ex_mc_done(ex_mc_done2), .mc_busy(mc_busy2), .stall_cycles(stall_cycles2)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles left until the done cycle, pending flush, captured pc, stall count
    int          m_left;
    logic        m_flush;
    logic [31:0] m_pc;
    longint      m_perf;

    typedef struct {
        logic        id, mem, start;
        logic [5:0]  len;
        logic        fr;
        logic [31:0] fpc;
        logic [5:0]  es;
        logic        ed, eb, ef;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic id, input logic mem, input logic start, input logic [5:0] len,
                        input logic fr, input logic [31:0] fpc,
                        output logic [5:0] o_stall, output logic o_done, output logic o_busy,
                        output logic o_flush);
        logic [5:0]  e_stall;
        logic        e_done, e_busy, n_flush;
        logic [31:0] n_pc;
        int          n_left;
        stallreq_id = id; stallreq_mem = mem; ex_mc_start = start;
        ex_mc_len = len; flush_req = fr; flush_pc = fpc;
        e_stall = 6'b0; e_done = 1'b0; e_busy = (m_left != 0);
        n_flush = 1'b0; n_pc = m_pc; n_left = m_left;
        if (m_flush) begin
            n_flush = 1'b0;
        end else if (fr) begin
            n_flush = 1'b1; n_pc = fpc; n_left = 0;
        end else if (mem) begin
            e_stall = 6'b011111;
        end else if (m_left > 1) begin
            e_stall = 6'b001111; n_left = m_left - 1;
        end else if (m_left == 1) begin
            e_done = 1'b1; n_left = 0;
        end else if (start && len <= 6'd1) begin
            e_done = 1'b1;
        end else if (start) begin
            e_stall = 6'b001111; n_left = int'(len) - 1;
        end else if (id) begin
            e_stall = 6'b000111;
        end
        @(negedge clk);
        chk("stall", 64'(stall), 64'(e_stall));
        chk("ex_mc_done", 64'(ex_mc_done), 64'(e_done));
        chk("mc_busy", 64'(mc_busy), 64'(e_busy));
        chk("flush", 64'(flush), 64'(m_flush));
        chk("new_pc", 64'(new_pc), 64'(m_pc));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_perf));
        chk("stall_cycles_sat", 64'(stall_cycles2), (m_perf > 3) ? 64'd3 : 64'(m_perf));
        o_stall = stall; o_done = ex_mc_done; o_busy = mc_busy; o_flush = flush;
        @(posedge clk);
        if (e_stall != 6'b0) m_perf++;
        m_left = n_left; m_flush = n_flush; m_pc = n_pc;
        #1;
    endtask

    task automatic setv(input int i, input logic id, input logic mem, input logic start,
                        input logic [5:0] len, input logic fr, input logic [31:0] fpc,
                        input logic [5:0] es, input logic ed, input logic eb, input logic ef);
        tbl[i] = '{id, mem, start, len, fr, fpc, es, ed, eb, ef};
    endtask

    initial begin
        logic [5:0] s; logic d, b, f;
        setv( 0, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv( 1, 1,0,0,6'd0, 0,32'h0,        6'b000111, 0,0,0);
        setv( 2, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv( 3, 1,1,0,6'd0, 0,32'h0,        6'b011111, 0,0,0);
        setv( 4, 0,0,1,6'd1, 0,32'h0,        6'b000000, 1,0,0);
        setv( 5, 0,0,1,6'd0, 0,32'h0,        6'b000000, 1,0,0);
        setv( 6, 0,0,1,6'd5, 0,32'h0,        6'b001111, 0,0,0);
        setv( 7, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv( 8, 1,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv( 9, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv(10, 0,0,0,6'd0, 0,32'h0,        6'b000000, 1,1,0);
        setv(11, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv(12, 0,1,1,6'd3, 0,32'h0,        6'b011111, 0,0,0);
        setv(13, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv(14, 0,0,1,6'd5, 0,32'h0,        6'b001111, 0,0,0);
        setv(15, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv(16, 0,1,0,6'd0, 0,32'h0,        6'b011111, 0,1,0);
        setv(17, 0,1,0,6'd0, 0,32'h0,        6'b011111, 0,1,0);
        setv(18, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv(19, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv(20, 0,0,0,6'd0, 0,32'h0,        6'b000000, 1,1,0);
        setv(21, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv(22, 0,0,1,6'd5, 0,32'h0,        6'b001111, 0,0,0);
        setv(23, 0,0,0,6'd0, 0,32'h0,        6'b001111, 0,1,0);
        setv(24, 0,0,0,6'd0, 1,32'hBFC00380, 6'b000000, 0,1,0);
        setv(25, 0,1,0,6'd0, 1,32'h12345678, 6'b000000, 0,0,1);
        setv(26, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);
        setv(27, 0,0,1,6'd5, 1,32'h80000180, 6'b000000, 0,0,0);
        setv(28, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,1);
        setv(29, 0,0,0,6'd0, 0,32'h0,        6'b000000, 0,0,0);

        // Reset held with active requests: everything idle
        rst = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b1; ex_mc_start = 1'b1;
        ex_mc_len = 6'd3; flush_req = 1'b0; flush_pc = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(ex_mc_done), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_busy", 64'(mc_busy), 64'd0);
        chk("rst_new_pc", 64'(new_pc), 64'd0);
        chk("rst_perf", 64'(stall_cycles), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_left = 0; m_flush = 1'b0; m_pc = 32'h0; m_perf = 0;
        step(0, 1, 1, 6'd3, 0, 32'hDEADBEEF, s, d, b, f);
        chk("post_rst_stall", 64'(s), 64'b011111);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].id, tbl[i].mem, tbl[i].start, tbl[i].len, tbl[i].fr, tbl[i].fpc, s, d, b, f);
            chk($sformatf("vec%0d_stall", i), 64'(s), 64'(tbl[i].es));
            chk($sformatf("vec%0d_done", i), 64'(d), 64'(tbl[i].ed));
            chk($sformatf("vec%0d_busy", i), 64'(b), 64'(tbl[i].eb));
            chk($sformatf("vec%0d_flush", i), 64'(f), 64'(tbl[i].ef));
            if (i == 25) chk("flush_new_pc", 64'(new_pc), 64'h0BFC00380);
        end
        @(negedge clk);
        chk("perf_after_table", 64'(stall_cycles), 64'd16);
        chk("perf_saturated", 64'(stall_cycles2), 64'd3);
        @(posedge clk); #1;

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), 6'($urandom_range(0, 9)),
                 ($urandom_range(0, 29) == 0), $urandom, s, d, b, f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
